// File: rtl/fifo_stream_reader.sv
// Read-side controller for syn_fifo: turns the FIFO's registered read port into a
// gapless valid/ready stream with flush support. Optional beat counter: STREAM_RD_CNT_EN.
module fifo_stream_reader #(
    parameter int WIDTH      = 8,
    parameter int OBUF_DEPTH = 3,
    parameter int CNT_WIDTH  = 16,
    localparam int OCC_WIDTH = $clog2(OBUF_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 rd_en_o,
    input  logic [WIDTH-1:0]     rdata_i,
    input  logic                 empty_i,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    input  logic                 m_ready_i,
    input  logic                 flush_i,
    output logic                 flush_done_o
`ifdef STREAM_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] rd_count_o
`endif
);

    localparam int PTR_W = $clog2(OBUF_DEPTH);

    if (OBUF_DEPTH < 2 || CNT_WIDTH < 1) begin : g_param_check
        $error("fifo_stream_reader: OBUF_DEPTH must be >= 2 and CNT_WIDTH >= 1");
    end

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [OCC_WIDTH-1:0] occ_q, occ_d;
    logic                 inflight_q;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [WIDTH-1:0]     buf_q [OBUF_DEPTH];

    logic                 push;
    logic                 pop;
    logic [OCC_WIDTH:0]   pending;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign m_valid_o = (state_q == RUN) && (occ_q != '0);
    assign m_data_o  = buf_q[head_q];

    // Words already requested count against buffer space, so a read is only
    // issued when its data is guaranteed a slot on arrival.
    assign pending = {1'b0, occ_q} + (OCC_WIDTH + 1)'(inflight_q);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d      = state_q;
        occ_d        = occ_q;
        head_d       = head_q;
        tail_d       = tail_q;
        rd_en_o      = 1'b0;
        flush_done_o = 1'b0;
        push         = 1'b0;
        pop          = m_valid_o && m_ready_i;

        case (state_q)
            RUN: begin
                rd_en_o = !rst_i && !empty_i && !flush_i &&
                          (pending < (OCC_WIDTH + 1)'(OBUF_DEPTH));
                if (flush_i) begin
                    state_d = FLUSH;
                    occ_d   = '0;
                    head_d  = '0;
                    tail_d  = '0;
                end else begin
                    push = inflight_q;
                    if (push) tail_d = ptr_inc(tail_q);
                    if (pop)  head_d = ptr_inc(head_q);
                    occ_d = occ_q + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
                end
            end
            FLUSH: begin
                // Keep draining; anything that arrives here is dropped.
                rd_en_o = !rst_i && !empty_i;
                if (!flush_i && empty_i && !inflight_q) begin
                    state_d      = RUN;
                    flush_done_o = !rst_i;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q    <= RUN;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= rd_en_o;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: the buffer is reset (it is only a few words) so m_data_o reads
        // zero out of reset instead of leaking stale or unknown contents.
        if (rst_i) begin
            for (int i = 0; i < OBUF_DEPTH; i++) buf_q[i] <= '0;
        end else if (push) begin
            buf_q[tail_q] <= rdata_i;
        end
    end

`ifdef STREAM_RD_CNT_EN
    logic [CNT_WIDTH-1:0] rd_count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_count_q <= '0;
        end else if (pop) begin
            rd_count_q <= rd_count_q + 1'b1;
        end
    end

    assign rd_count_o = rd_count_q;
`endif

endmodule
